instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter NOP_CNT_W, default 4, giving the width of the NOP repeat count.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn_i, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port cmd_valid_i, input, 1, command valid.
REQ-005 SHALL have port cmd_ready_o, output, 1, command accepted when both valid and ready are high.
REQ-006 SHALL have port cmd_op_i, input, 4, command kind of type enc_cmd_t: ADD, SUB, ADDI, LW, SW, BEQ, JAL, LI, NOP, MUL.
REQ-007 SHALL have ports cmd_rd_i, cmd_rs1_i and cmd_rs2_i, each input, 5, register indices.
REQ-008 SHALL have port cmd_imm_i, input, 32, signed immediate; for NOP, bits [NOP_CNT_W-1:0] hold the repeat count.
REQ-009 SHALL have port instr_valid_o, output, 1, encoded word valid.
REQ-010 SHALL have port instr_ready_i, input, 1, downstream fetch/issue ready.
REQ-011 SHALL have port instr_o, output, 32, RV32 instruction word.
REQ-012 SHALL have port err_o, output, 1, one-cycle pulse on an illegal command.
REQ-013 SHALL have port busy_o, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, EMIT, EMIT_LO and NOPS.
- IDLE: cmd_ready_o = 1.
- Accept on cycle N; first word registered with instr_valid_o = 1 at N+1 (latency 1).
REQ-015 SHALL hold instr_o and instr_valid_o stable while instr_valid_o = 1 and instr_ready_i = 0.
REQ-016 SHALL leave a word only on the cycle where instr_valid_o and instr_ready_i are both high.
REQ-017 SHALL raise cmd_ready_o in EMIT when instr_ready_i = 1 and the word is the last of its command, giving back-to-back throughput of 1 word per cycle.
REQ-018 SHALL encode each command as follows:
- ADD/SUB: OP_ALU, F3_ADD_SUB, F7_ALU_NORMAL for ADD, F7_ALU_MODIFIED for SUB.
- MUL: OP_ALU, F3_MUL, F7_MUL.
- ADDI: OP_ALU_I.
- LW: OP_LW, funct3 010.
- SW: OP_SW, S-format.
- BEQ: OP_BRANCH, F3_BEQ, B-format.
- JAL: OP_JAL, J-format.
REQ-019 SHALL expand LI into two words: LUI rd, (imm[31:12] + imm[11]) mod 2^20 in EMIT, then ADDI rd, rd, imm[11:0] in EMIT_LO; both words are always emitted.
REQ-020 SHALL expand NOP with count c into c+1 copies of NOP_INSTR_HEX (0x00000033) via NOPS; a count counter decrements on each handshake and the FSM exits at zero.
REQ-021 SHALL treat the following commands as illegal:
- ADDI/LW/SW with imm outside [-2048, 2047];
- BEQ with imm odd or outside 13-bit signed range;
- JAL with imm odd or outside 21-bit signed range;
- an unknown cmd_op_i.
REQ-022 SHALL, on an illegal command, still accept it, pulse err_o at N+1, emit no word and remain in IDLE.
REQ-023 SHALL emit rd = x0 unchanged; the block does not suppress it.
REQ-024 SHALL ignore cmd_* inputs when cmd_ready_o = 0.

Reset
REQ-025 SHALL, on rstn_i low, immediately force state IDLE, instr_valid_o = 0, instr_o = NOP_INSTR_HEX, err_o = 0, busy_o = 0 and the NOP counter to 0.
REQ-026 SHALL, on reset mid-LI or mid-NOPS, discard the remaining words; the first command after release is encoded fresh.
REQ-027 SHALL drive cmd_ready_o = 1 in the first cycle after reset release.

Configuration
REQ-028 SHALL, with ENC_MUL_EN defined, encode MUL per REQ-018.
REQ-029 SHALL, without ENC_MUL_EN, treat MUL as illegal per REQ-022 and include no MUL encoding logic.

Structure
REQ-030 SHALL place enc_cmd_t and the encoder FSM state typedef in riscv_pkg, reusing opcode_t, f3_alu_t, f3_branch_t, f3_mul_t, f7_alu_modifier_t and NOP_INSTR_HEX.
REQ-031 SHALL place format packing (R/I/S/B/U/J) in a combinational sub-module instr_format_pack; the FSM, counter and output register live in instr_encoder.

Verification
REQ-032 ADDI rd=1, rs1=0, imm=5, ready held high -> instr_o = 0x00500093 at N+1, then cmd_ready_o = 1.
REQ-033 LI rd=5, imm=0x12345FFF -> 0x123462B7 then 0xFFF28293; with instr_ready_i = 0 for 3 cycles, word 1 is held stable.
REQ-034 SUB rd=3, rs1=1, rs2=2 -> 0x402081B3; MUL with the same operands -> 0x022081B3 with ENC_MUL_EN, else err_o pulses with no word emitted.
REQ-035 NOP count=3 -> exactly four 0x00000033 handshakes, busy_o = 1 throughout, then IDLE.
REQ-036 ADDI imm=2048, then BEQ imm=3 -> two err_o pulses and no instr_valid_o.
REQ-037 rstn_i low between LI words -> the second word is never emitted, instr_valid_o = 0, and after release ADD rd=1, rs1=2, rs2=3 -> 0x003100B3.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32 encoding constants and instruction-encoder types
//
// Purpose: shared opcode/funct enums, the canonical NOP word, the encoder
// command kinds, FSM states and the word-format selector used by
// instr_format_pack. MUL constants are always present; whether MUL is encoded
// is decided in instr_encoder by the ENC_MUL_EN macro.
package riscv_pkg;

  typedef enum logic [6:0] {
    OP_ALU    = 7'b0110011,
    OP_ALU_I  = 7'b0010011,
    OP_LW     = 7'b0000011,
    OP_SW     = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_LUI    = 7'b0110111
  } opcode_t;

  typedef enum logic [2:0] { F3_ADD_SUB = 3'b000 } f3_alu_t;
  typedef enum logic [2:0] { F3_BEQ     = 3'b000 } f3_branch_t;
  typedef enum logic [2:0] { F3_MUL     = 3'b000 } f3_mul_t;

  typedef enum logic [6:0] {
    F7_ALU_NORMAL   = 7'b0000000,
    F7_ALU_MODIFIED = 7'b0100000,
    F7_MUL          = 7'b0000001
  } f7_alu_modifier_t;

  // Word-sized load/store width.
  localparam logic [2:0]  F3_LW_SW      = 3'b010;
  // add x0, x0, x0
  localparam logic [31:0] NOP_INSTR_HEX = 32'h0000_0033;

  typedef enum logic [3:0] {
    CMD_ADD  = 4'd0,
    CMD_SUB  = 4'd1,
    CMD_ADDI = 4'd2,
    CMD_LW   = 4'd3,
    CMD_SW   = 4'd4,
    CMD_BEQ  = 4'd5,
    CMD_JAL  = 4'd6,
    CMD_LI   = 4'd7,
    CMD_NOP  = 4'd8,
    CMD_MUL  = 4'd9
  } enc_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMIT    = 2'd1,
    EMIT_LO = 2'd2,
    NOPS    = 2'd3
  } enc_state_t;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

endpackage

// File: rtl/instr_format_pack.sv
// rtl/instr_format_pack.sv - combinational RV32 R/I/S/B/U/J field packer
//
// Ports:
//   fmt_i      word format selector
//   opcode_i   7-bit major opcode
//   funct3_i   3-bit funct3 (ignored for U/J)
//   funct7_i   7-bit funct7 (R only)
//   rd_i, rs1_i, rs2_i  register indices
//   imm_i      immediate; U format takes the upper 20 bits from imm_i[31:12]
//   instr_o    packed 32-bit instruction word
module instr_format_pack
  import riscv_pkg::*;
(
  input  fmt_t        fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o
);

  always_comb begin
    instr_o = NOP_INSTR_HEX;
    case (fmt_i)
      FMT_R: instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                        imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: instr_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                        rd_i, opcode_i};
      default: instr_o = NOP_INSTR_HEX;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - command-to-RV32 instruction encoder with output handshake
//
// Purpose: accepts one encoder command per handshake and emits one or more
// RV32 words on a valid/ready stream (LI -> LUI+ADDI, NOP c -> c+1 NOPs).
// Illegal commands are accepted, flagged with a one-cycle err_o, and dropped.
// Optional feature macro: ENC_MUL_EN (when undefined, MUL is illegal).
//
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake
//   cmd_op_i           command kind (enc_cmd_t)
//   cmd_rd_i/rs1_i/rs2_i register indices
//   cmd_imm_i          signed immediate / NOP repeat count in [NOP_CNT_W-1:0]
//   instr_valid_o/instr_ready_i  output word handshake
//   instr_o            registered instruction word
//   err_o              one-cycle pulse after an illegal command is accepted
//   busy_o             high whenever the FSM is not IDLE
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int NOP_CNT_W = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  enc_cmd_t    cmd_op_i,
  input  logic [4:0]  cmd_rd_i,
  input  logic [4:0]  cmd_rs1_i,
  input  logic [4:0]  cmd_rs2_i,
  input  logic [31:0] cmd_imm_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic        err_o,
  output logic        busy_o
);

  enc_state_t           state_q, state_d;
  logic [31:0]          instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 li_pend_q, li_pend_d;
  logic [NOP_CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]           li_rd_q, li_rd_d;
  logic [11:0]          li_lo_q, li_lo_d;

  logic out_hs, accept, use_lo;
  logic fits12, fits13, fits21;

  logic        dec_legal, dec_li, dec_nop;
  fmt_t        dec_fmt;
  logic [6:0]  dec_op, dec_f7;
  logic [2:0]  dec_f3;
  logic [31:0] dec_imm;

  fmt_t        pk_fmt;
  logic [6:0]  pk_op;
  logic [2:0]  pk_f3;
  logic [4:0]  pk_rd, pk_rs1;
  logic [31:0] pk_imm, pk_word;

  assign out_hs = valid_q & instr_ready_i;
  // Ready in EMIT only when the held word is the command's last and it is
  // leaving this cycle, so single-word commands stream at one per cycle.
  assign cmd_ready_o = (state_q == IDLE) |
                       ((state_q == EMIT) & ~li_pend_q & instr_ready_i);
  assign accept = cmd_valid_i & cmd_ready_o;

  // Sign-extension tests: every bit above the sign bit equals the sign bit.
  assign fits12 = (cmd_imm_i[31:11] == {21{cmd_imm_i[11]}});
  assign fits13 = (cmd_imm_i[31:12] == {20{cmd_imm_i[12]}});
  assign fits21 = (cmd_imm_i[31:20] == {12{cmd_imm_i[20]}});

  always_comb begin
    dec_legal = 1'b1;
    dec_li    = 1'b0;
    dec_nop   = 1'b0;
    dec_fmt   = FMT_R;
    dec_op    = OP_ALU;
    dec_f3    = F3_ADD_SUB;
    dec_f7    = F7_ALU_NORMAL;
    dec_imm   = cmd_imm_i;
    case (cmd_op_i)
      CMD_ADD:  dec_f7 = F7_ALU_NORMAL;
      CMD_SUB:  dec_f7 = F7_ALU_MODIFIED;
      CMD_ADDI: begin
        dec_fmt = FMT_I; dec_op = OP_ALU_I; dec_legal = fits12;
      end
      CMD_LW: begin
        dec_fmt = FMT_I; dec_op = OP_LW; dec_f3 = F3_LW_SW; dec_legal = fits12;
      end
      CMD_SW: begin
        dec_fmt = FMT_S; dec_op = OP_SW; dec_f3 = F3_LW_SW; dec_legal = fits12;
      end
      CMD_BEQ: begin
        dec_fmt = FMT_B; dec_op = OP_BRANCH; dec_f3 = F3_BEQ;
        dec_legal = fits13 & ~cmd_imm_i[0];
      end
      CMD_JAL: begin
        dec_fmt = FMT_J; dec_op = OP_JAL; dec_legal = fits21 & ~cmd_imm_i[0];
      end
      CMD_LI: begin
        // ADDI sign-extends its 12 bits, so round the upper part up when bit 11 is set.
        dec_fmt = FMT_U; dec_op = OP_LUI; dec_li = 1'b1;
        dec_imm = {cmd_imm_i[31:12] + {19'd0, cmd_imm_i[11]}, 12'd0};
      end
      CMD_NOP: dec_nop = 1'b1;
`ifdef ENC_MUL_EN
      CMD_MUL: begin
        dec_f3 = F3_MUL; dec_f7 = F7_MUL;
      end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  // The packer is shared: it builds the LI low word (ADDI rd, rd, lo) while
  // EMIT holds the LUI, and otherwise encodes the incoming command. Both
  // uses never coincide because EMIT with LI pending does not accept.
  assign use_lo = (state_q == EMIT) & li_pend_q;

  always_comb begin
    if (use_lo) begin
      pk_fmt = FMT_I;
      pk_op  = OP_ALU_I;
      pk_f3  = F3_ADD_SUB;
      pk_rd  = li_rd_q;
      pk_rs1 = li_rd_q;
      pk_imm = {{20{li_lo_q[11]}}, li_lo_q};
    end else begin
      pk_fmt = dec_fmt;
      pk_op  = dec_op;
      pk_f3  = dec_f3;
      pk_rd  = cmd_rd_i;
      pk_rs1 = cmd_rs1_i;
      pk_imm = dec_imm;
    end
  end

  instr_format_pack u_pack (
    .fmt_i    (pk_fmt),
    .opcode_i (pk_op),
    .funct3_i (pk_f3),
    .funct7_i (dec_f7),
    .rd_i     (pk_rd),
    .rs1_i    (pk_rs1),
    .rs2_i    (cmd_rs2_i),
    .imm_i    (pk_imm),
    .instr_o  (pk_word)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    li_pend_d = li_pend_q;
    cnt_d     = cnt_q;
    li_rd_d   = li_rd_q;
    li_lo_d   = li_lo_q;

    case (state_q)
      IDLE: ;
      EMIT: begin
        if (out_hs) begin
          if (li_pend_q) begin
            state_d   = EMIT_LO;
            instr_d   = pk_word;
            li_pend_d = 1'b0;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      EMIT_LO: begin
        if (out_hs) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      NOPS: begin
        if (out_hs) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else begin
            cnt_d = cnt_q - {{(NOP_CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Accepting in EMIT implies the last word is leaving, so the case above
    // has already set IDLE/valid=0; an illegal command leaves it that way.
    if (accept) begin
      if (!dec_legal) begin
        err_d = 1'b1;
      end else if (dec_nop) begin
        state_d = NOPS;
        valid_d = 1'b1;
        instr_d = NOP_INSTR_HEX;
        cnt_d   = cmd_imm_i[NOP_CNT_W-1:0];
      end else begin
        state_d   = EMIT;
        valid_d   = 1'b1;
        instr_d   = pk_word;
        li_pend_d = dec_li;
        if (dec_li) begin
          li_rd_d = cmd_rd_i;
          li_lo_d = cmd_imm_i[11:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      instr_q   <= NOP_INSTR_HEX;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      li_pend_q <= 1'b0;
      cnt_q     <= '0;
      li_rd_q   <= 5'd0;
      li_lo_q   <= 12'd0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      li_pend_q <= li_pend_d;
      cnt_q     <= cnt_d;
      li_rd_q   <= li_rd_d;
      li_lo_q   <= li_lo_d;
    end
  end

  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign err_o         = err_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed table-driven bench for instr_encoder
module tb_instr_encoder;
  import riscv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  enc_cmd_t    cmd_op_i = CMD_ADD;
  logic [4:0]  cmd_rd_i = 5'd0;
  logic [4:0]  cmd_rs1_i = 5'd0;
  logic [4:0]  cmd_rs2_i = 5'd0;
  logic [31:0] cmd_imm_i = 32'd0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b1;
  logic [31:0] instr_o;
  logic        err_o;
  logic        busy_o;

  instr_encoder #(.NOP_CNT_W(4)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_op_i      (cmd_op_i),
    .cmd_rd_i      (cmd_rd_i),
    .cmd_rs1_i     (cmd_rs1_i),
    .cmd_rs2_i     (cmd_rs2_i),
    .cmd_imm_i     (cmd_imm_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .err_o         (err_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    enc_cmd_t    op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        exp_err;
    logic [31:0] exp_word;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Presents a command, waits (bounded) for ready, handshakes it and returns
  // at the falling edge of cycle N+1.
  task automatic send(input enc_cmd_t op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int t;
    t = 0;
    cmd_op_i = op; cmd_rd_i = rd; cmd_rs1_i = rs1; cmd_rs2_i = rs2; cmd_imm_i = imm;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready_o}, 32'd1);
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic nop_run(input logic [31:0] cnt, input int exp_hs);
    int hs;
    hs = 0;
    instr_ready_i = 1'b1;
    send(CMD_NOP, 5'd0, 5'd0, 5'd0, cnt);
    for (int c = 0; c < 40 && instr_valid_o; c++) begin
      hs++;
      chk("nop_word", instr_o, NOP_INSTR_HEX);
      chk("nop_busy", {31'd0, busy_o}, 32'd1);
      @(negedge clk_i);
    end
    chk("nop_handshakes", hs, exp_hs);
    chk("nop_end_busy", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{CMD_ADDI, 5'd1, 5'd0, 5'd0, 32'd5,          1'b0, 32'h0050_0093};
    vecs[1]  = '{CMD_SUB,  5'd3, 5'd1, 5'd2, 32'd0,          1'b0, 32'h4020_81B3};
    vecs[2]  = '{CMD_ADD,  5'd0, 5'd1, 5'd2, 32'd0,          1'b0, 32'h0020_8033};
    vecs[3]  = '{CMD_LW,   5'd6, 5'd2, 5'd0, 32'hFFFF_FFFC,  1'b0, 32'hFFC1_2303};
    vecs[4]  = '{CMD_SW,   5'd0, 5'd2, 5'd5, 32'd8,          1'b0, 32'h0051_2423};
    vecs[5]  = '{CMD_BEQ,  5'd0, 5'd1, 5'd2, 32'd8,          1'b0, 32'h0020_8463};
    vecs[6]  = '{CMD_BEQ,  5'd0, 5'd0, 5'd0, 32'd4094,       1'b0, 32'h7E00_0FE3};
    vecs[7]  = '{CMD_JAL,  5'd1, 5'd0, 5'd0, 32'd2048,       1'b0, 32'h0010_00EF};
    vecs[8]  = '{CMD_JAL,  5'd0, 5'd0, 5'd0, 32'hFFFF_FFFE,  1'b0, 32'hFFFF_F06F};
    vecs[9]  = '{CMD_ADDI, 5'd2, 5'd0, 5'd0, 32'hFFFF_F800,  1'b0, 32'h8000_0113};
    vecs[10] = '{CMD_ADDI, 5'd1, 5'd0, 5'd0, 32'd2047,       1'b0, 32'h7FF0_0093};
    vecs[11] = '{CMD_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048,       1'b1, 32'd0};
    vecs[12] = '{CMD_BEQ,  5'd0, 5'd1, 5'd2, 32'd3,          1'b1, 32'd0};
    vecs[13] = '{CMD_BEQ,  5'd0, 5'd1, 5'd2, 32'd4096,       1'b1, 32'd0};
    vecs[14] = '{CMD_JAL,  5'd1, 5'd0, 5'd0, 32'd3,          1'b1, 32'd0};
    vecs[15] = '{CMD_JAL,  5'd1, 5'd0, 5'd0, 32'h0010_0000,  1'b1, 32'd0};
    vecs[16] = '{CMD_LW,   5'd1, 5'd2, 5'd0, 32'hFFFF_F7FF,  1'b1, 32'd0};
    vecs[17] = '{enc_cmd_t'(4'hF), 5'd1, 5'd2, 5'd3, 32'd0,  1'b1, 32'd0};
`ifdef ENC_MUL_EN
    vecs[18] = '{CMD_MUL,  5'd3, 5'd1, 5'd2, 32'd0,          1'b0, 32'h0220_81B3};
`else
    vecs[18] = '{CMD_MUL,  5'd3, 5'd1, 5'd2, 32'd0,          1'b1, 32'd0};
`endif

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, NOP_INSTR_HEX);
    chk("rst_err",   {31'd0, err_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    rstn_i = 1'b1;
    #1 chk("rst_release_ready", {31'd0, cmd_ready_o}, 32'd1);
    @(negedge clk_i);

    // Single-word commands, back-to-back where legal
    instr_ready_i = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      chk($sformatf("v%0d_err", i), {31'd0, err_o}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_valid", i), {31'd0, instr_valid_o}, {31'd0, ~vecs[i].exp_err});
      if (!vecs[i].exp_err) begin
        chk($sformatf("v%0d_word", i), instr_o, vecs[i].exp_word);
        chk($sformatf("v%0d_ready", i), {31'd0, cmd_ready_o}, 32'd1);
      end else begin
        chk($sformatf("v%0d_busy", i), {31'd0, busy_o}, 32'd0);
        @(negedge clk_i);
        chk($sformatf("v%0d_err_pulse", i), {31'd0, err_o}, 32'd0);
        chk($sformatf("v%0d_no_word", i), {31'd0, instr_valid_o}, 32'd0);
      end
    end
    @(negedge clk_i);
    chk("table_drain", {31'd0, instr_valid_o}, 32'd0);

    // LI with a 3-cycle output stall
    instr_ready_i = 1'b0;
    send(CMD_LI, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    chk("li_w1", instr_o, 32'h1234_62B7);
    chk("li_w1_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("li_busy", {31'd0, busy_o}, 32'd1);
    chk("li_no_ready", {31'd0, cmd_ready_o}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk($sformatf("li_hold%0d", k), instr_o, 32'h1234_62B7);
      chk($sformatf("li_hold_valid%0d", k), {31'd0, instr_valid_o}, 32'd1);
    end
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    chk("li_w2", instr_o, 32'hFFF2_8293);
    chk("li_w2_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("li_w2_busy", {31'd0, busy_o}, 32'd1);
    @(negedge clk_i);
    chk("li_done_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("li_done_busy", {31'd0, busy_o}, 32'd0);

    // NOP expansion: count 3 and count 0
    nop_run(32'd3, 4);
    nop_run(32'd0, 1);

    // Reset between LI words
    instr_ready_i = 1'b0;
    send(CMD_LI, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    chk("rli_w1", instr_o, 32'h1234_62B7);
    #2 rstn_i = 1'b0;
    #1;
    chk("rli_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rli_instr", instr_o, NOP_INSTR_HEX);
    chk("rli_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    instr_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk($sformatf("rli_no_w2_%0d", k), {31'd0, instr_valid_o}, 32'd0);
    end
    send(CMD_ADD, 5'd1, 5'd2, 5'd3, 32'd0);
    chk("post_rst_add", instr_o, 32'h0031_00B3);
    chk("post_rst_add_valid", {31'd0, instr_valid_o}, 32'd1);
    @(negedge clk_i);
    chk("post_rst_drain", {31'd0, instr_valid_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
